read_port_sched: RTL and testbench

//  Decode-to-regfile read-port scheduler for the mini CPU. Registers each decoded

---
 rtl/read_port_sched.sv | 139 +++++++++++++
 tb/tb_read_port_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_port_sched.sv
// Decode-to-regfile read-port scheduler: a single holding stage that picks the read-port
// fields and gates issue on RAW hazards using per-register pending-write counters.

module read_port_sched_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  // Underflow is flagged and never wraps. Overflow cannot occur because the hazard check holds issue back.
  assign err = dec & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 cnt <= '0;
    else if (inc & ~dec)        cnt <= cnt + 1'b1;
    else if (dec & ~inc & ~err) cnt <= cnt - 1'b1;
endmodule

module read_port_sched #(
  parameter int AW    = 3,
  parameter int OPW   = 6,
  parameter int CNT_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_opcode,
  input  logic [AW-1:0]  in_r1,
  input  logic [AW-1:0]  in_r2,
  input  logic [AW-1:0]  in_r3,
  input  logic [AW-1:0]  in_dst,
  input  logic           in_dst_we,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_sel,
  output logic [AW-1:0]  out_rd_a,
  output logic [AW-1:0]  out_rd_b,
  output logic [OPW-1:0] out_opcode,
  output logic [AW-1:0]  out_dst,
  output logic           out_dst_we,
  input  logic           wb_valid,
  input  logic [AW-1:0]  wb_reg,
  output logic           hazard_stall,
  output logic           sb_err
);
  localparam int NREG = 1 << AW;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic [1:0]     sel;
    logic [AW-1:0]  rd_a;
    logic [AW-1:0]  rd_b;
    logic [OPW-1:0] op;
    logic [AW-1:0]  dst;
    logic           we;
  } req_t;

  req_t q, d;
  logic held, alive, hazard, issue, accept;
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            inc, dec, err;

  function automatic logic [1:0] sel_dec(input logic [OPW-1:0] op);
    logic [1:0] s;
    s = 2'b00;
    case (op[5:4])
      2'b00: if (op[1:0] == 2'b11) s = 2'b01;
      2'b10: s = 2'b10;
      2'b11:
        case (op[3:0])
          4'b1001, 4'b1010: s = 2'b01;
          4'b1100, 4'b1110: s = 2'b10;
          default: s = 2'b00;
        endcase
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  always_comb begin
    d     = '0;
    d.sel = sel_dec(in_opcode);
    d.op  = in_opcode;
    d.dst = in_dst;
    d.we  = in_dst_we;
    case (d.sel)
      2'b01:   begin d.rd_a = in_r1; d.rd_b = in_r2; end
      2'b10:   begin d.rd_a = in_r2; d.rd_b = in_r1; end
      default: begin d.rd_a = in_r2; d.rd_b = in_r3; end
    endcase
  end

  // Counts are used registered: a writeback frees a hazard only from the following cycle.
  assign hazard = (cnt[q.rd_a] != '0) | (cnt[q.rd_b] != '0) | (q.we & (cnt[q.dst] == CMAX));
  assign out_valid    = held & ~hazard;
  assign hazard_stall = held & hazard;
  assign issue        = out_valid & out_ready;
  assign in_ready     = alive & (~held | issue);
  assign accept       = in_valid & in_ready;

  assign out_sel    = q.sel;
  assign out_rd_a   = q.rd_a;
  assign out_rd_b   = q.rd_b;
  assign out_opcode = q.op;
  assign out_dst    = q.dst;
  assign out_dst_we = q.we;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      held  <= 1'b0;
      alive <= 1'b0;
      q     <= '0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        held <= 1'b1;
        q    <= d;
      end else if (issue) begin
        held <= 1'b0;
      end
    end

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    assign inc[g] = issue & q.we & (q.dst == AW'(g));
    assign dec[g] = wb_valid & (wb_reg == AW'(g));
    read_port_sched_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc[g]), .dec(dec[g]), .cnt(cnt[g]), .err(err[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    sb_err <= 1'b0;
    else if (|err) sb_err <= 1'b1;
endmodule

// File: tb/tb_read_port_sched.sv
// Bench for read_port_sched: decode table, directed hazard/handshake sequences, and a
// randomized run against an arithmetic scoreboard model.

module tb_read_port_sched;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid, in_ready, in_dst_we, out_valid, out_ready, out_dst_we;
  logic       wb_valid, hazard_stall, sb_err;
  logic [5:0] in_opcode, out_opcode;
  logic [2:0] in_r1, in_r2, in_r3, in_dst, out_rd_a, out_rd_b, out_dst, wb_reg;
  logic [1:0] out_sel;

  always #5 clk = ~clk;

  read_port_sched #(.AW(3), .OPW(6), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_r1(in_r1), .in_r2(in_r2), .in_r3(in_r3),
    .in_dst(in_dst), .in_dst_we(in_dst_we), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_rd_a(out_rd_a), .out_rd_b(out_rd_b), .out_opcode(out_opcode),
    .out_dst(out_dst), .out_dst_we(out_dst_we), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .hazard_stall(hazard_stall), .sb_err(sb_err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] r3, input logic [2:0] dst, input logic we);
    in_valid = 1'b1; in_opcode = op; in_r1 = r1; in_r2 = r2; in_r3 = r3;
    in_dst = dst; in_dst_we = we;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [2:0] r1, r2, r3;
    logic [1:0] sel;
    logic [2:0] a, b;
  } vec_t;
  vec_t tbl[10];

  // Reference decode straight from the opcode rules
  function automatic logic [1:0] ref_sel(input logic [5:0] op);
    int grp, lo;
    grp = int'(op[5:4]);
    lo  = int'(op[3:0]);
    if (grp == 2) return 2'b10;
    if (grp == 3) begin
      if (lo == 9 || lo == 10) return 2'b01;
      if (lo == 12 || lo == 14) return 2'b10;
      return 2'b00;
    end
    if (grp == 0 && op[1:0] == 2'b11) return 2'b01;
    return 2'b00;
  endfunction

  int         cm[8];
  logic       h_v, h_we, m_err, haz, ov, st, ir, iss;
  logic [1:0] h_sel;
  logic [2:0] h_a, h_b, h_dst;
  logic [5:0] h_op;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 0; in_opcode = 0; in_r1 = 0; in_r2 = 0; in_r3 = 0; in_dst = 0; in_dst_we = 0;
    out_ready = 0; wb_valid = 0; wb_reg = 0;

    tbl[0] = '{6'b111001, 3'd3, 3'd4, 3'd7, 2'b01, 3'd3, 3'd4};
    tbl[1] = '{6'b000011, 3'd1, 3'd2, 3'd6, 2'b01, 3'd1, 3'd2};
    tbl[2] = '{6'b000010, 3'd1, 3'd2, 3'd6, 2'b00, 3'd2, 3'd6};
    tbl[3] = '{6'b010011, 3'd5, 3'd0, 3'd3, 2'b00, 3'd0, 3'd3};
    tbl[4] = '{6'b100111, 3'd7, 3'd6, 3'd1, 2'b10, 3'd6, 3'd7};
    tbl[5] = '{6'b111010, 3'd2, 3'd3, 3'd4, 2'b01, 3'd2, 3'd3};
    tbl[6] = '{6'b111100, 3'd2, 3'd3, 3'd4, 2'b10, 3'd3, 3'd2};
    tbl[7] = '{6'b111110, 3'd0, 3'd5, 3'd1, 2'b10, 3'd5, 3'd0};
    tbl[8] = '{6'b111011, 3'd0, 3'd5, 3'd1, 2'b00, 3'd5, 3'd1};
    tbl[9] = '{6'b110001, 3'd6, 3'd7, 3'd2, 2'b00, 3'd7, 3'd2};

    #12;
    chk("reset_outputs", 64'({in_ready, out_valid, hazard_stall, sb_err, out_sel, out_rd_a,
        out_rd_b, out_opcode, out_dst, out_dst_we}), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    // Decode / port-mapping table
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].r3, 3'd0, 1'b0);
      tick();
      idle();
      chk($sformatf("decode%0d", i), 64'({out_valid, out_sel, out_rd_a, out_rd_b, out_opcode}),
          64'({1'b1, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].op}));
      tick();
    end

    // RAW hazard on port A, released one cycle after writeback
    offer(6'b010000, 3'd0, 3'd0, 3'd0, 3'd5, 1'b1);
    tick();
    chk("raw_writer_valid", 64'(out_valid), 64'(1));
    offer(6'b010000, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0);
    tick();
    idle();
    chk("raw_stall", 64'({out_valid, hazard_stall, in_ready}), 64'(3'b010));
    tick();
    chk("raw_stall_hold", 64'(hazard_stall), 64'(1));
    wb_valid = 1'b1; wb_reg = 3'd5;
    #1;
    chk("raw_no_bypass", 64'(out_valid), 64'(0));
    tick();
    wb_valid = 1'b0;
    chk("raw_release", 64'({out_valid, hazard_stall}), 64'(2'b10));
    tick();
    chk("raw_drained", 64'({out_valid, in_ready}), 64'(2'b01));

    // Backpressure: held outputs stable, then one issue per cycle
    out_ready = 1'b0;
    offer(6'b100000, 3'd1, 3'd2, 3'd3, 3'd4, 1'b0);
    tick();
    offer(6'b000011, 3'd6, 3'd7, 3'd0, 3'd1, 1'b0);
    chk("bp_blocked", 64'(in_ready), 64'(0));
    repeat (2) tick();
    chk("bp_stable", 64'({out_valid, in_ready, out_sel, out_rd_a, out_rd_b, out_opcode, out_dst}),
        64'({1'b1, 1'b0, 2'b10, 3'd2, 3'd1, 6'b100000, 3'd4}));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_on_issue", 64'(in_ready), 64'(1));
    tick();
    idle();
    chk("bp_second", 64'({out_valid, out_sel, out_rd_a, out_rd_b, out_opcode, out_dst}),
        64'({1'b1, 2'b01, 3'd6, 3'd7, 6'b000011, 3'd1}));
    tick();
    chk("bp_empty", 64'(out_valid), 64'(0));

    // Counter saturation on dst=2
    offer(6'b010000, 3'd0, 3'd0, 3'd0, 3'd2, 1'b1);
    repeat (4) tick();
    idle();
    chk("sat_stall", 64'({out_valid, hazard_stall}), 64'(2'b01));
    tick();
    chk("sat_hold", 64'({out_valid, hazard_stall}), 64'(2'b01));
    wb_valid = 1'b1; wb_reg = 3'd2;
    tick();
    wb_valid = 1'b0;
    chk("sat_release", 64'(out_valid), 64'(1));
    tick();
    chk("sat_issued", 64'(out_valid), 64'(0));
    wb_valid = 1'b1; wb_reg = 3'd2;
    repeat (3) tick();
    wb_valid = 1'b0;
    offer(6'b010000, 3'd0, 3'd2, 3'd0, 3'd0, 1'b0);
    tick();
    idle();
    chk("sat_drained", 64'({out_valid, sb_err}), 64'(2'b10));
    tick();

    // Underflow error and simultaneous issue+writeback on one register
    wb_valid = 1'b1; wb_reg = 3'd6;
    tick();
    wb_valid = 1'b0;
    chk("err_set", 64'(sb_err), 64'(1));
    repeat (2) tick();
    chk("err_sticky", 64'(sb_err), 64'(1));
    offer(6'b010000, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1);
    tick();
    tick();
    offer(6'b010000, 3'd0, 3'd1, 3'd0, 3'd0, 1'b0);
    wb_valid = 1'b1; wb_reg = 3'd1;
    #1;
    chk("both_writer_valid", 64'(out_valid), 64'(1));
    tick();
    wb_valid = 1'b0;
    idle();
    chk("both_cnt_kept", 64'(hazard_stall), 64'(1));
    wb_valid = 1'b1; wb_reg = 3'd1;
    tick();
    wb_valid = 1'b0;
    chk("both_one_left", 64'(out_valid), 64'(1));
    tick();

    // Async reset with a held, stalled instruction and cnt[5]=2
    offer(6'b010000, 3'd0, 3'd0, 3'd0, 3'd5, 1'b1);
    repeat (2) tick();
    offer(6'b010000, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0);
    tick();
    idle();
    chk("rst_held_stall", 64'(hazard_stall), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({in_ready, out_valid, hazard_stall, sb_err, out_sel, out_rd_a,
        out_rd_b, out_opcode, out_dst, out_dst_we}), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(in_ready), 64'(1));
    offer(6'b010000, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0);
    tick();
    idle();
    chk("rst_counts_clear", 64'({out_valid, hazard_stall}), 64'(2'b10));
    tick();

    // Randomized run against the reference model
    wb_valid = 1'b0;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) cm[r] = 0;
    h_v = 0; h_we = 0; m_err = 0; h_sel = 0; h_a = 0; h_b = 0; h_dst = 0; h_op = 0;
    for (int c = 0; c < 1500; c++) begin
      int base;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_opcode = 6'($urandom);
      in_r1 = 3'($urandom); in_r2 = 3'($urandom); in_r3 = 3'($urandom);
      in_dst = 3'($urandom); in_dst_we = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_reg    = 3'($urandom);
      if ($urandom_range(0, 9) != 0) begin
        base = int'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++)
          if (cm[(base + k) % 8] != 0) begin
            wb_reg = 3'((base + k) % 8);
            break;
          end
      end
      #1;
      haz = h_v && (cm[h_a] != 0 || cm[h_b] != 0 || (h_we && cm[h_dst] == 3));
      ov  = h_v && !haz;
      st  = h_v && haz;
      iss = ov && out_ready;
      ir  = !h_v || iss;
      chk("random", 64'({out_valid, hazard_stall, in_ready, sb_err, out_sel, out_rd_a, out_rd_b,
          out_opcode, out_dst, out_dst_we}),
          64'({ov, st, ir, m_err, h_sel, h_a, h_b, h_op, h_dst, h_we}));
      @(posedge clk);
      if (wb_valid && cm[wb_reg] == 0) m_err = 1'b1;
      for (int r = 0; r < 8; r++) begin
        int n;
        n = cm[r];
        if (iss && h_we && int'(h_dst) == r) n = n + 1;
        if (wb_valid && int'(wb_reg) == r) n = n - 1;
        cm[r] = (n < 0) ? 0 : n;
      end
      if (in_valid && ir) begin
        h_v = 1'b1; h_sel = ref_sel(in_opcode); h_op = in_opcode;
        h_dst = in_dst; h_we = in_dst_we;
        if (h_sel == 2'b01)      begin h_a = in_r1; h_b = in_r2; end
        else if (h_sel == 2'b10) begin h_a = in_r2; h_b = in_r1; end
        else                     begin h_a = in_r2; h_b = in_r3; end
      end else if (iss) begin
        h_v = 1'b0;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
